// File: rtl/decoupled_router.sv
// decoupled_router: steers NUM_IN ready/valid streams onto 2**AW registered outputs,
// with one round-robin arbiter and one output slot per destination.
module decoupled_router #(
    parameter int NUM_IN = 4,
    parameter int DW     = 16,
    parameter int AW     = 2,
    parameter int SW     = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DW-1:0]     InPld,
    input  logic [NUM_IN*AW-1:0]     InDst,
    input  logic [NUM_IN-1:0]        InVld,
    output logic [NUM_IN-1:0]        InRdy,
    output logic [(2**AW)*DW-1:0]    OutPld,
    output logic [(2**AW)*SW-1:0]    OutSrc,
    output logic [2**AW-1:0]         OutVld,
    input  logic [2**AW-1:0]         OutRdy
);
    localparam int NUM_OUT = 2**AW;

    logic [SW-1:0]      ptr [NUM_OUT];
    logic [SW-1:0]      gnt_idx [NUM_OUT];
    logic [NUM_OUT-1:0] gnt_vld;
    logic [SW:0]        sum;
    logic [SW-1:0]      idx;

    // Scan each output's requesters starting at its pointer; first hit wins.
    always_comb begin
        gnt_vld = '0;
        sum     = '0;
        idx     = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            gnt_idx[o] = '0;
            for (int k = 0; k < NUM_IN; k++) begin
                sum = {1'b0, ptr[o]} + (SW+1)'(k);
                idx = sum >= (SW+1)'(NUM_IN) ? SW'(sum - (SW+1)'(NUM_IN)) : SW'(sum);
                if ((!OutVld[o] || OutRdy[o]) && !gnt_vld[o] && InVld[idx]
                    && InDst[idx*AW +: AW] == AW'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = idx;
                end
            end
        end
    end

    // Each input targets one output, so at most one grant can reach any InRdy bit.
    always_comb begin
        InRdy = '0;
        for (int o = 0; o < NUM_OUT; o++)
            if (gnt_vld[o] && rst_n) InRdy[gnt_idx[o]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OutVld <= '0;
            OutPld <= '0;
            OutSrc <= '0;
            for (int o = 0; o < NUM_OUT; o++) ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                if (gnt_vld[o]) begin
                    OutVld[o]            <= 1'b1;
                    OutPld[o*DW +: DW]   <= InPld[gnt_idx[o]*DW +: DW];
                    OutSrc[o*SW +: SW]   <= gnt_idx[o];
                    ptr[o]               <= gnt_idx[o] == SW'(NUM_IN-1) ? '0 : gnt_idx[o] + 1'b1;
                end else if (OutRdy[o]) begin
                    OutVld[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_decoupled_router.sv
// tb_decoupled_router: directed steps with a scoreboard of expected output beats.
module tb_decoupled_router;
    localparam int NI = 4, DW = 16, AW = 2, NO = 4, SW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NI*DW-1:0] in_pld = '0;
    logic [NI*AW-1:0] in_dst = '0;
    logic [NI-1:0]    in_vld = '0;
    logic [NI-1:0]    in_rdy;
    logic [NO*DW-1:0] out_pld;
    logic [NO*SW-1:0] out_src;
    logic [NO-1:0]    out_vld;
    logic [NO-1:0]    out_rdy = '1;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [SW-1:0] src;
        logic [DW-1:0] pld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    decoupled_router #(.NUM_IN(NI), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .InPld(in_pld), .InDst(in_dst), .InVld(in_vld), .InRdy(in_rdy),
        .OutPld(out_pld), .OutSrc(out_src), .OutVld(out_vld), .OutRdy(out_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [AW-1:0] d, input logic [DW-1:0] p);
        in_vld[i]          = v;
        in_dst[i*AW +: AW] = d;
        in_pld[i*DW +: DW] = p;
    endtask

    // Check InRdy, record accepted beats, clock once, then check every output beat.
    task automatic step(input string tag, input logic [NI-1:0] er, input logic [NO-1:0] ev);
        exp_t e;
        #1;
        chk({tag, ".rdy"}, 32'(in_rdy), 32'(er));
        for (int i = 0; i < NI; i++)
            if (er[i]) sb.push_back('{dst: in_dst[i*AW +: AW], src: SW'(i), pld: in_pld[i*DW +: DW]});
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 32'(out_vld), 32'(ev));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".pld"}, 32'(out_pld[e.dst*DW +: DW]), 32'(e.pld));
            chk({tag, ".src"}, 32'(out_src[e.dst*SW +: SW]), 32'(e.src));
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) drive(i, 1'b1, 2'd0, 16'h0100 + 16'(i));
        #3;
        chk("rst.rdy", 32'(in_rdy), 0);
        chk("rst.vld", 32'(out_vld), 0);
        chk("rst.pld", 32'(out_pld), 0);
        chk("rst.src", 32'(out_src), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold.rdy", 32'(in_rdy), 0);
        chk("rst_hold.vld", 32'(out_vld), 0);
        rst_n = 1'b1;
        step("rst_first", 4'b0001, 4'b0001);
        in_vld = '0;
        step("drain", 4'b0000, 4'b0000);

        drive(2, 1'b1, 2'd1, 16'hA5A5);
        step("single", 4'b0100, 4'b0010);
        in_vld = '0;
        step("single_drain", 4'b0000, 4'b0000);

        for (int i = 0; i < NI; i++) drive(i, 1'b1, 2'd3, 16'h3000 + 16'(i));
        step("rr0", 4'b0001, 4'b1000);
        step("rr1", 4'b0010, 4'b1000);
        step("rr2", 4'b0100, 4'b1000);
        step("rr3", 4'b1000, 4'b1000);
        step("rr4", 4'b0001, 4'b1000);
        in_vld = '0;
        step("rr_drain", 4'b0000, 4'b0000);

        out_rdy = 4'b1110;
        drive(1, 1'b1, 2'd0, 16'h1234);
        step("bp_load", 4'b0010, 4'b0001);
        in_vld = '0;
        drive(3, 1'b1, 2'd0, 16'h3333);
        drive(2, 1'b1, 2'd2, 16'h2222);
        step("bp_stall", 4'b0100, 4'b0101);
        chk("bp_hold.pld", 32'(out_pld[0 +: DW]), 32'h1234);
        chk("bp_hold.src", 32'(out_src[0 +: SW]), 1);
        in_vld[2] = 1'b0;
        out_rdy = 4'b1111;
        step("bp_release", 4'b1000, 4'b0001);
        in_vld = '0;
        step("bp_drain", 4'b0000, 4'b0000);

        drive(0, 1'b1, 2'd2, 16'h0A0A);
        step("wrap", 4'b0001, 4'b0100);
        drive(0, 1'b1, 2'd2, 16'h0B0B);
        drive(1, 1'b1, 2'd2, 16'h1B1B);
        step("wrap_ptr1", 4'b0010, 4'b0100);
        in_vld = '0;
        step("wrap_drain", 4'b0000, 4'b0000);

        out_rdy = 4'b0000;
        drive(0, 1'b1, 2'd0, 16'hC000);
        drive(1, 1'b1, 2'd1, 16'hC001);
        drive(3, 1'b1, 2'd3, 16'hC003);
        step("arst_load", 4'b1011, 4'b1011);
        in_vld = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", 32'(out_vld), 0);
        chk("arst.pld", 32'(out_pld), 0);
        for (int i = 0; i < NI; i++) drive(i, 1'b1, 2'd1, 16'hD000 + 16'(i));
        out_rdy = 4'b1111;
        #1;
        chk("arst.rdy", 32'(in_rdy), 0);
        #1;
        rst_n = 1'b1;
        step("arst_ptr", 4'b0001, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
